// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the core's single unified memory port between instruction fetch and
// the load/store unit. One request is latched at a time, driven onto the
// memory port, and its response is routed back to whoever issued it. Fetch
// responses that were in flight across a control-flow redirect (flush) are
// swallowed. Data normally wins contested arbitration, but after STARVE_LIMIT
// consecutive contested data grants fetch is given the next contested slot.
//
// Parameters:
//   STARVE_LIMIT   contested data grants before fetch is forced through (1..15)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 control-flow redirect; kills pending/in-flight fetch
//   if_req_*              fetch request (valid/addr) and one-cycle ready pulse
//   if_resp_*             fetch response (one-cycle valid pulse + data)
//   d_req_*               load/store request (valid/addr/we/wdata/wstrb), ready
//   d_resp_*              load/store response (one-cycle valid pulse + data)
//   mem_req_*             request to memory, fields held while valid
//   mem_resp_*            response from memory (reads and writes)
//   busy                  a transaction is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,

   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,

   input  logic        d_req_valid,
   input  logic [31:0] d_req_addr,
   input  logic        d_req_we,
   input  logic [31:0] d_req_wdata,
   input  logic [3:0]  d_req_wstrb,
   output logic        d_req_ready,
   output logic        d_resp_valid,
   output logic [31:0] d_resp_data,

   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_we,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,

   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      state_reg, state_next;
   logic        owner_fetch_reg, owner_fetch_next;
   logic        drop_reg, drop_next;
   logic [3:0]  starve_cnt_reg, starve_cnt_next;
   logic [31:0] addr_reg, addr_next;
   logic        we_reg, we_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [3:0]  wstrb_reg, wstrb_next;
   logic        if_resp_valid_reg, if_resp_valid_next;
   logic [31:0] if_resp_data_reg, if_resp_data_next;
   logic        d_resp_valid_reg, d_resp_valid_next;
   logic [31:0] d_resp_data_reg, d_resp_data_next;

   logic fetch_eff;
   logic contested;
   logic fetch_wins;

   // A fetch raised in the same cycle as a redirect is already stale.
   assign fetch_eff  = if_req_valid & ~flush;
   assign contested  = fetch_eff & d_req_valid;
   assign fetch_wins = fetch_eff & (~d_req_valid | (starve_cnt_reg == LIMIT));

   always_comb begin
      state_next         = state_reg;
      owner_fetch_next   = owner_fetch_reg;
      drop_next          = drop_reg;
      starve_cnt_next    = starve_cnt_reg;
      addr_next          = addr_reg;
      we_next            = we_reg;
      wdata_next         = wdata_reg;
      wstrb_next         = wstrb_reg;
      if_resp_valid_next = 1'b0;
      if_resp_data_next  = if_resp_data_reg;
      d_resp_valid_next  = 1'b0;
      d_resp_data_next   = d_resp_data_reg;
      if_req_ready       = 1'b0;
      d_req_ready        = 1'b0;

      case (state_reg)
         IDLE: begin
            drop_next = 1'b0;
            if (fetch_wins) begin
               if_req_ready     = 1'b1;
               owner_fetch_next = 1'b1;
               addr_next        = if_req_addr;
               we_next          = 1'b0;
               wdata_next       = 32'd0;
               wstrb_next       = 4'd0;
               starve_cnt_next  = 4'd0;
               state_next       = ISSUE;
            end else if (d_req_valid) begin
               d_req_ready      = 1'b1;
               owner_fetch_next = 1'b0;
               addr_next        = d_req_addr;
               we_next          = d_req_we;
               wdata_next       = d_req_wdata;
               wstrb_next       = d_req_wstrb;
               // Only grants that actually beat a waiting fetch count
               // toward starvation; the counter saturates at the limit.
               if (contested && (starve_cnt_reg < LIMIT)) begin
                  starve_cnt_next = starve_cnt_reg + 4'd1;
               end
               state_next = ISSUE;
            end
         end

         ISSUE: begin
            // The memory request is never retracted; a flushed fetch is
            // allowed to finish and its data is discarded on return.
            if (owner_fetch_reg && flush) begin
               drop_next = 1'b1;
            end
            if (mem_req_ready) begin
               state_next = WAIT;
            end
         end

         WAIT: begin
            if (mem_resp_valid) begin
               state_next = IDLE;
               drop_next  = 1'b0;
               if (owner_fetch_reg) begin
                  // A redirect in the response cycle itself also kills it.
                  if_resp_valid_next = ~(drop_reg | flush);
                  if_resp_data_next  = mem_resp_data;
               end else begin
                  d_resp_valid_next = 1'b1;
                  d_resp_data_next  = mem_resp_data;
               end
            end else if (owner_fetch_reg && flush) begin
               drop_next = 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         owner_fetch_reg   <= 1'b0;
         drop_reg          <= 1'b0;
         starve_cnt_reg    <= 4'd0;
         addr_reg          <= 32'd0;
         we_reg            <= 1'b0;
         wdata_reg         <= 32'd0;
         wstrb_reg         <= 4'd0;
         if_resp_valid_reg <= 1'b0;
         if_resp_data_reg  <= 32'd0;
         d_resp_valid_reg  <= 1'b0;
         d_resp_data_reg   <= 32'd0;
      end else begin
         state_reg         <= state_next;
         owner_fetch_reg   <= owner_fetch_next;
         drop_reg          <= drop_next;
         starve_cnt_reg    <= starve_cnt_next;
         addr_reg          <= addr_next;
         we_reg            <= we_next;
         wdata_reg         <= wdata_next;
         wstrb_reg         <= wstrb_next;
         if_resp_valid_reg <= if_resp_valid_next;
         if_resp_data_reg  <= if_resp_data_next;
         d_resp_valid_reg  <= d_resp_valid_next;
         d_resp_data_reg   <= d_resp_data_next;
      end
   end

   assign mem_req_valid = (state_reg == ISSUE);
   assign mem_req_addr  = addr_reg;
   assign mem_req_we    = we_reg;
   assign mem_req_wdata = wdata_reg;
   assign mem_req_wstrb = wstrb_reg;
   assign if_resp_valid = if_resp_valid_reg;
   assign if_resp_data  = if_resp_data_reg;
   assign d_resp_valid  = d_resp_valid_reg;
   assign d_resp_data   = d_resp_data_reg;
   assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Stimulus issues fetch/data requests and, on each grant it predicts, pushes
// the expected transaction (owner, fields, read data from a reference memory)
// into a scoreboard. A memory responder with its own storage services the
// port with random wait states. A monitor checks the memory-side fields and
// pops the scoreboard whenever a response is due.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        if_req_valid = 1'b0;
   logic [31:0] if_req_addr = '0;
   logic        if_req_ready;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        d_req_valid = 1'b0;
   logic [31:0] d_req_addr = '0;
   logic        d_req_we = 1'b0;
   logic [31:0] d_req_wdata = '0;
   logic [3:0]  d_req_wstrb = '0;
   logic        d_req_ready;
   logic        d_resp_valid;
   logic [31:0] d_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
      .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .busy(busy)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   typedef struct {
      bit          fetch;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
   } txn_t;

   txn_t sb[$];

   // ---------------- memories (reference and responder) ----------------
   logic [31:0] ref_mem [int];
   logic [31:0] rsp_mem [int];

   function automatic logic [31:0] init_word(input int idx);
      return 32'h5A00_0000 ^ (32'(idx) * 32'h0101_0013);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(input int idx);
      return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
   endfunction

   function automatic logic [31:0] rsp_rd(input int idx);
      return rsp_mem.exists(idx) ? rsp_mem[idx] : init_word(idx);
   endfunction

   // ---------------- memory responder ----------------
   int          rdly_force = -1;
   int          pdly_force = -1;
   bit          stray = 1'b0;
   int          rs = 0;
   int          rcnt = 0;
   int          rsp_d = 0;
   int          rsp_idx = 0;
   logic [31:0] rdata_hold = '0;

   initial forever begin
      @(posedge clk);
      #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      if (!rst_n) begin
         rs = 0;
      end else if (stray) begin
         mem_resp_valid = 1'b1;
         stray = 1'b0;
      end else begin
         if (rs == 0 && mem_req_valid) begin
            rsp_d = (rdly_force >= 0) ? rdly_force : int'($urandom_range(0, 2));
            if (rsp_d == 0) rs = 3;
            else begin rcnt = rsp_d - 1; rs = 1; end
         end else if (rs == 1) begin
            if (rcnt == 0) rs = 3;
            else rcnt--;
         end else if (rs == 2) begin
            if (rcnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = rdata_hold;
               rs = 0;
            end else rcnt--;
         end
         if (rs == 3) begin
            mem_req_ready = 1'b1;
            rsp_idx    = int'(mem_req_addr >> 2);
            rdata_hold = rsp_rd(rsp_idx);
            if (mem_req_we) rsp_mem[rsp_idx] = merge(rdata_hold, mem_req_wdata, mem_req_wstrb);
            rcnt = (pdly_force >= 0) ? pdly_force : int'($urandom_range(0, 2));
            rs = 2;
         end
      end
   end

   // ---------------- monitor ----------------
   bit   expect_resp = 1'b0;
   bit   exp_drop = 1'b0;
   bit   drop_seen = 1'b0;
   txn_t mt;
   int   if_resp_cnt = 0;
   int   d_resp_cnt = 0;

   initial forever begin
      @(negedge clk);
      if (if_resp_valid === 1'b1) if_resp_cnt++;
      if (d_resp_valid === 1'b1) d_resp_cnt++;
      if (!rst_n) begin
         sb.delete();
         expect_resp = 1'b0;
         drop_seen   = 1'b0;
      end else if (expect_resp) begin
         expect_resp = 1'b0;
         if (sb.size() == 0) begin
            chk("resp_without_txn", 64'(sb.size()), 64'd1);
         end else begin
            mt = sb.pop_front();
            chk("resp_valid", {if_resp_valid, d_resp_valid},
                {(mt.fetch && !exp_drop), !mt.fetch});
            if (mt.fetch && !exp_drop) chk("if_resp_data", if_resp_data, mt.rdata);
            if (!mt.fetch && !mt.we) chk("d_resp_data", d_resp_data, mt.rdata);
         end
         drop_seen = 1'b0;
      end else begin
         chk("no_spurious_resp", {if_resp_valid, d_resp_valid}, 2'b00);
         if (sb.size() > 0 && sb[0].fetch && flush) drop_seen = 1'b1;
         if (mem_req_valid) begin
            if (sb.size() == 0) chk("mem_req_without_txn", 64'(sb.size()), 64'd1);
            else begin
               chk("mem_req_addr", mem_req_addr, sb[0].addr);
               chk("mem_req_we", mem_req_we, sb[0].we);
               if (sb[0].we) chk("mem_req_wdata_wstrb", {mem_req_wdata, mem_req_wstrb},
                                 {sb[0].wdata, sb[0].wstrb});
            end
         end
         if (mem_resp_valid && sb.size() > 0) begin
            expect_resp = 1'b1;
            exp_drop    = drop_seen;
         end
      end
   end

   // ---------------- stimulus and reference model ----------------
   bit          f_pend = 0, d_pend = 0, flush_drv = 0;
   logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
   bit          d_we = 0;
   logic [3:0]  d_wstrb = '0;
   bit          model_busy = 0;
   int          streak = 0;
   int          last_grant = 0;   // 0 none, 1 fetch, 2 data

   task automatic new_fetch(input logic [31:0] a);
      f_pend = 1; f_addr = a;
   endtask

   task automatic new_data(input logic [31:0] a, input bit we, input logic [31:0] wd,
                           input logic [3:0] st);
      d_pend = 1; d_addr = a; d_we = we; d_wdata = wd; d_wstrb = st;
   endtask

   function automatic logic [31:0] rand_addr();
      return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
   endfunction

   task automatic step();
      bit eff_f, exp_f, exp_d;
      txn_t t;
      int idx;
      @(posedge clk);
      #1;
      if_req_valid = f_pend; if_req_addr = f_addr;
      d_req_valid = d_pend; d_req_addr = d_addr; d_req_we = d_we;
      d_req_wdata = d_wdata; d_req_wstrb = d_wstrb;
      flush = flush_drv;
      @(negedge clk);
      last_grant = 0;
      chk("busy", busy, model_busy);
      if (model_busy) begin
         chk("no_ready_while_busy", {if_req_ready, d_req_ready}, 2'b00);
         if (mem_resp_valid) model_busy = 0;
      end else begin
         eff_f = f_pend && !flush_drv;
         exp_f = 0; exp_d = 0;
         if (eff_f && d_pend) begin
            if (streak == LIMIT) exp_f = 1; else exp_d = 1;
         end else if (eff_f) exp_f = 1;
         else if (d_pend) exp_d = 1;
         chk("req_ready", {if_req_ready, d_req_ready}, {exp_f, exp_d});
         if (exp_f) begin
            idx = int'(f_addr >> 2);
            t = '{fetch: 1, addr: f_addr, we: 0, wdata: '0, wstrb: '0, rdata: ref_rd(idx)};
            sb.push_back(t);
            streak = 0; f_pend = 0; model_busy = 1; last_grant = 1;
         end else if (exp_d) begin
            idx = int'(d_addr >> 2);
            t = '{fetch: 0, addr: d_addr, we: d_we, wdata: d_wdata, wstrb: d_wstrb,
                  rdata: ref_rd(idx)};
            sb.push_back(t);
            if (d_we) ref_mem[idx] = merge(ref_rd(idx), d_wdata, d_wstrb);
            if (eff_f && streak < LIMIT) streak++;
            d_pend = 0; model_busy = 1; last_grant = 2;
         end
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      flush_drv = 0;
      while ((model_busy || f_pend || d_pend) && g < 100) begin
         step();
         g++;
      end
      step();
      chk("drain_in_time", 64'(g < 100), 64'd1);
   endtask

   string seq;
   int    guard;
   int    cnt_if, cnt_d;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // ---- reset state ----
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs",
          64'({if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid,
               mem_req_valid, mem_req_we, mem_req_wstrb, busy} != '0) |
          64'({d_resp_data, mem_req_addr, mem_req_wdata} != '0), 64'd0);
      rst_n = 1'b1;

      // ---- single load, zero-wait memory ----
      rdly_force = 0; pdly_force = 0;
      ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
      rsp_mem[32'h100 >> 2] = 32'hDEADBEEF;
      new_data(32'h100, 0, 32'h0, 4'h0);
      step();
      chk("load_grant_T", last_grant, 2);
      step();
      chk("load_mem_req_T1", {mem_req_valid, mem_req_addr, mem_req_we}, {1'b1, 32'h100, 1'b0});
      step();
      step();
      chk("load_resp_T3", {d_resp_valid, d_resp_data, busy}, {1'b1, 32'hDEADBEEF, 1'b0});

      // ---- contention: both requesters held ----
      seq = "";
      guard = 0;
      while (seq.len() < 10 && guard < 200) begin
         if (!f_pend) new_fetch(rand_addr());
         if (!d_pend) new_data(rand_addr(), 1'($urandom), $urandom, 4'($urandom));
         step();
         if (last_grant == 1) seq = {seq, "F"};
         else if (last_grant == 2) seq = {seq, "D"};
         guard++;
      end
      total++;
      if (seq != "DDDDFDDDDF") begin
         bad++;
         $display("FAIL grant_sequence: got %s want DDDDFDDDDF", seq);
      end
      drain();

      // ---- store with memory wait states ----
      rdly_force = 3; pdly_force = 1;
      cnt_if = if_resp_cnt; cnt_d = d_resp_cnt;
      new_data(32'h20, 1, 32'h1234, 4'b0011);
      drain();
      chk("store_one_d_resp", d_resp_cnt - cnt_d, 1);
      chk("store_no_if_resp", if_resp_cnt - cnt_if, 0);
      rdly_force = 0; pdly_force = 0;
      new_fetch(32'h20);
      drain();

      // ---- flush while fetch is waiting on memory ----
      pdly_force = 3;
      cnt_if = if_resp_cnt;
      new_fetch(32'h40);
      step();
      chk("flush_fetch_grant", last_grant, 1);
      step();
      flush_drv = 1;
      step();
      flush_drv = 0;
      drain();
      chk("flushed_fetch_no_resp", if_resp_cnt - cnt_if, 0);
      pdly_force = 0;
      new_fetch(32'h80);
      drain();
      chk("fetch_after_flush_resp", if_resp_cnt - cnt_if, 1);

      // ---- flush in IDLE with only a fetch pending ----
      new_fetch(32'h44);
      flush_drv = 1;
      step();
      chk("flush_idle_no_grant", {64'(last_grant), 63'd0, if_req_ready}, 64'd0);
      flush_drv = 0;
      step();
      chk("flush_idle_grant_next", last_grant, 1);
      drain();

      // ---- randomized traffic ----
      rdly_force = -1; pdly_force = -1;
      for (int i = 0; i < 400; i++) begin
         if (!f_pend && $urandom_range(0, 2) == 0) new_fetch(rand_addr());
         if (!d_pend && $urandom_range(0, 2) == 0)
            new_data(rand_addr(), 1'($urandom), $urandom, 4'($urandom_range(1, 15)));
         flush_drv = ($urandom_range(0, 5) == 0);
         step();
      end
      drain();

      // ---- asynchronous reset while waiting on memory ----
      rdly_force = 0; pdly_force = 5;
      new_data(32'h8, 0, 32'h0, 4'h0);
      step();
      step();
      step();
      chk("pre_reset_busy", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          64'({if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid,
               mem_req_valid, mem_req_we, mem_req_wstrb, busy} != '0) |
          64'({d_resp_data, mem_req_addr, mem_req_wdata} != '0), 64'd0);
      model_busy = 0; streak = 0; flush_drv = 0; f_pend = 0; d_pend = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt_if = if_resp_cnt; cnt_d = d_resp_cnt;
      stray = 1'b1;
      repeat (4) step();
      chk("stray_resp_ignored", (if_resp_cnt - cnt_if) + (d_resp_cnt - cnt_d), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single unified memory port between the instruction-fetch requester and the execution stage's load/store requester. The execution unit produces the effective load/store address. This block latches one request at a time, drives it onto the memory port, and routes the response back to its owner. It sits between fetch/MEM-stage logic and the memory interface. It drops stale fetch responses after a control-flow redirect and bounds fetch starvation under heavy data traffic.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive contested data grants after which fetch wins the next contested arbitration (legal range 1..15)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  control-flow redirect (jump_signal from execute); invalidates fetch traffic
- if_req_valid  input  1  fetch request
- if_req_addr  input  32  fetch address
- if_req_ready  output  1  one-cycle pulse: fetch request latched
- if_resp_valid  output  1  one-cycle pulse: fetch data valid
- if_resp_data  output  32  fetch read data
- d_req_valid  input  1  load/store request
- d_req_addr  input  32  effective address (rs1 + imm)
- d_req_we  input  1  1 = store
- d_req_wdata  input  32  store data
- d_req_wstrb  input  4  byte strobes
- d_req_ready  output  1  one-cycle pulse: data request latched
- d_resp_valid  output  1  one-cycle pulse: load data valid or store complete
- d_resp_data  output  32  load data (store: memory's rdata, unspecified)
- mem_req_valid  output  1  request to memory
- mem_req_ready  input  1  memory accepts request
- mem_req_addr / mem_req_we / mem_req_wdata / mem_req_wstrb  output  32/1/32/4  latched request fields
- mem_resp_valid  input  1  memory response (reads and writes)
- mem_resp_data  input  32  memory read data
- busy  output  1  state != IDLE

## Operation
- FSM states:
  - IDLE: arbitrate. On any grant, latch the request, pulse the owner's *_req_ready, record owner, go to ISSUE.
  - ISSUE: mem_req_valid=1, fields held stable. On mem_req_ready, go to WAIT.
  - WAIT: on mem_resp_valid, register the response and go to IDLE.
- Arbitration in IDLE:
  - Effective fetch request = if_req_valid & ~flush.
  - Only one requester: grant it.
  - Both requesting: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt (4 bits):
  - Increments on each contested data grant.
  - Clears on any fetch grant.
  - Saturates at STARVE_LIMIT.
- Response routing: registered. The owner's *_resp_valid pulses and *_resp_data loads one cycle after mem_resp_valid.
- Drop flag:
  - Set when flush=1 while owner=fetch in ISSUE or WAIT.
  - The transaction still completes on the memory side; mem_req_valid is never retracted.
  - A dropped fetch response produces no if_resp_valid. The flag clears on return to IDLE.
- Flush never affects data transactions.
- mem_resp_valid outside WAIT is ignored.
- Only one transaction is outstanding at any time.

## Timing
- All outputs reset to 0: FSM=IDLE, starve_cnt=0, drop=0. Reset asynchronously, including mid-transaction; mem_req_valid drops immediately.
- Best-case latency:
  - Accept in cycle T (IDLE, *_req_ready=1).
  - mem_req_valid from T+1.
  - mem_req_ready at T+1, mem_resp_valid at T+2.
  - *_resp_valid at T+3.
- Back-to-back: the next grant can occur in the cycle the response is delivered, i.e. the first IDLE cycle. Period is 3 cycles with zero-wait memory.
- Requesters hold *_req_valid and fields until their *_req_ready pulse. The arbiter samples fields only in the grant cycle.
- flush coincident with a fetch-only request in IDLE: no grant, no if_req_ready.
- flush coincident with mem_resp_valid for fetch in WAIT: response dropped.

## Test plan
- Single load: d_req addr=0x100 at T; memory ready at T+1, resp 0xDEADBEEF at T+2 -> d_req_ready@T, mem_req_valid@T+1 with addr 0x100 we=0, d_resp_valid@T+3 with data 0xDEADBEEF, busy low @T+3.
- Contention with STARVE_LIMIT=4: if_req_valid and d_req_valid held continuously -> grant sequence D,D,D,D,F,D,D,D,D,F; starve_cnt returns to 0 after each F.
- Store with wait states: d_req we=1 wstrb=0b0011 wdata=0x1234; mem_req_ready low 3 cycles -> mem_req fields stable throughout, d_resp_valid exactly once after mem_resp_valid, no if_resp_valid.
- Flush during fetch WAIT: fetch addr 0x40 granted, flush pulsed in WAIT -> memory response consumed, if_resp_valid never asserts, next fetch at 0x80 returns normally.
- Flush in IDLE with fetch-only request -> no if_req_ready that cycle; granted the following cycle once flush=0.
- Async reset asserted in WAIT -> all outputs 0 immediately. A later stray mem_resp_valid in IDLE produces no *_resp_valid.
